vid_pattern_gen: RTL and testbench
==================================

Name: vid_pattern_gen

Overview:
- Pixel-clock-domain video source that produces the same stream a DVI receiver presents to img_proc: 24-bit pixel data plus DE, HSYNC and VSYNC.
- Generates a full programmable-raster timing sequence and a selectable test pattern.
- Lets img_proc and the VGA output path be brought up and regression-tested without an HDMI source attached.
- Sits in place of the receiver output, muxed ahead of img_proc.

Parameters:
- H_ACTIVE, 640: active pixels per line; must be a multiple of 8.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: active lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: sync asserted level; 0 = active-low, 1 = active-high.
- CHK_LOG2, 5: checkerboard square size is 2^CHK_LOG2 pixels.

Ports:
- clk  in  1  pixel clock; all logic is in this domain.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronized externally.
- en  in  1  run enable.
- pat_sel  in  2  pattern select: 0 colour bars, 1 checkerboard, 2 horizontal gradient, 3 solid.
- solid_rgb  in  24  colour used by pattern 3, packed {R,B,G}.
- data_o  out  24  pixel data packed {R[23:16],B[15:8],G[7:0]}, the same packing as the receiver output.
- vde_o  out  1  data enable; high during active pixels.
- hsync_o  out  1  horizontal sync at SYNC_POL level.
- vsync_o  out  1  vertical sync at SYNC_POL level.
- x_o  out  12  active-area column of the pixel currently on data_o.
- y_o  out  12  active-area row of the pixel currently on data_o.
- sof_o  out  1  one-cycle pulse coincident with pixel (0,0).

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters h_cnt and v_cnt are 12-bit.
- h_cnt counts 0..H_TOTAL-1, then wraps to 0. v_cnt increments only on an h_cnt wrap and wraps to 0 after V_TOTAL-1.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- hsync asserted while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
- vsync asserted while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC. vsync changes on the same edge as the h_cnt=0 line start.
- Output latency: exactly 1 clk. Every output is registered from the current counter state, so all outputs stay mutually aligned.
- Reset values: h_cnt=0, v_cnt=0, data_o=0, vde_o=0, x_o=0, y_o=0, sof_o=0, hsync_o=vsync_o=~SYNC_POL.
- States: IDLE and RUN.
  - IDLE: counters held at 0; outputs at their reset values.
  - IDLE->RUN when en=1. The first clock edge in RUN issues pixel (0,0) on the outputs, with sof_o=1.
  - RUN->IDLE when en=0 is sampled; the frame is abandoned and outputs return to reset values on the next edge.
  - Reset mid-frame forces IDLE immediately (asynchronous).
- pat_sel and solid_rgb are latched only at h_cnt=0, v_cnt=0. Mid-frame changes take effect from the next frame; there is never a torn frame.
- Outside the active region: data_o=0, x_o and y_o hold their last values.
- Pattern 0, colour bars: 8 equal bars of width H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black, each channel 8'hFF or 8'h00.
  - Bar index comes from a bar-width down-counter plus a 3-bit index; no divider.
  - The bar counter reloads at the start of every active line.
- Pattern 1, checkerboard: white when x[CHK_LOG2]^y[CHK_LOG2]=1, otherwise black.
- Pattern 2, gradient: R=G=B=x[7:0]; wraps every 256 pixels.
- Pattern 3, solid: solid_rgb.
- Parameter values violating H_ACTIVE%8==0 or any timing field of 0 are unsupported. The RTL carries an elaboration-time assertion for these.

Decomposition:
- Package vid_pkg:
  - pattern enum pat_e (PAT_BARS, PAT_CHECK, PAT_GRAD, PAT_SOLID);
  - the 8-entry colour-bar constant table in {R,B,G} packing;
  - a pack_rbg(r,g,b) function.
- Sub-module vid_timing holds the counters, IDLE/RUN state, and raw de/hs/vs/x/y/sof.
- Top-level vid_pattern_gen adds pattern latching, pixel generation, and the output register stage.

Test Plan:
Small raster for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=24); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=7); CHK_LOG2=2.
- Reset, then en=1 -> sof_o at the first edge; sof_o period 168 clks; vde_o high 16 clks per line, 64 per frame; hsync_o low 3 clks, starting 2 clks after vde_o falls.
- vsync_o -> low for exactly 24 clks per frame, starting 120 clks after sof_o; 0 pulses of hsync_o are missing.
- pat_sel=0 -> each bar is 2 pixels wide; x=0,1 give 24'hFFFFFF; x=2 gives yellow {FF,00,FF}; x=14,15 give 0.
- pat_sel=1 -> row 0: x=0..3 black, x=4..7 white; row 4 does not exist (only 4 active lines), so check row 0 against row 3.
- pat_sel switched from 2 to 3 at pixel (5,1) -> the rest of that frame stays gradient; the next frame is entirely solid_rgb.
- en=0 mid-line, or rst_n pulsed mid-line -> next edge: vde_o=0, syncs inactive, data_o=0; after re-enable, sof_o restarts at (0,0).

Source files
------------

// File: rtl/vid_pkg.sv
// Shared types and constants for the video test-pattern source.
// Pixel words are packed {R,B,G} to match the DVI receiver output.
package vid_pkg;

  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_SOLID = 2'd3
  } pat_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [23:0] pack_rbg(input logic [7:0] r, input logic [7:0] g,
                                           input logic [7:0] b);
    return {r, b, g};
  endfunction

  // Entry 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_TABLE = {
    pack_rbg(8'h00, 8'h00, 8'h00),
    pack_rbg(8'h00, 8'h00, 8'hFF),
    pack_rbg(8'hFF, 8'h00, 8'h00),
    pack_rbg(8'hFF, 8'h00, 8'hFF),
    pack_rbg(8'h00, 8'hFF, 8'h00),
    pack_rbg(8'h00, 8'hFF, 8'hFF),
    pack_rbg(8'hFF, 8'hFF, 8'h00),
    pack_rbg(8'hFF, 8'hFF, 8'hFF)
  };

endpackage

// File: rtl/vid_pattern_gen_if.sv
// Video stream as presented to img_proc: pixel data, DE, syncs and raster position.
interface vid_pattern_gen_if;
  import vid_pkg::*;

  logic [23:0]      data_o;
  logic             vde_o;
  logic             hsync_o;
  logic             vsync_o;
  logic [CNT_W-1:0] x_o;
  logic [CNT_W-1:0] y_o;
  logic             sof_o;

  modport master (
    output data_o, vde_o, hsync_o, vsync_o, x_o, y_o, sof_o
  );

  modport slave (
    input data_o, vde_o, hsync_o, vsync_o, x_o, y_o, sof_o
  );
endinterface

// File: rtl/vid_timing.sv
// Raster counters and IDLE/RUN control; produces unregistered de/hs/vs/x/y/sof
// describing the pixel that will be issued on the coming clock edge.
module vid_timing
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             run,
  output logic             de,
  output logic             hs,
  output logic             vs,
  output logic             sof,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  if ((H_ACTIVE % 8) != 0 || H_ACTIVE <= 0 || H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 ||
      V_ACTIVE <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0) begin : g_bad_raster
    $error("vid_timing: unsupported raster parameters");
  end

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // run means "a pixel is issued on this edge"; it is true on the IDLE->RUN edge
  // too, so the entry edge already carries pixel (0,0).
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (en)  state_next = ST_RUN;
      ST_RUN:  if (!en) state_next = ST_IDLE;
      default:          state_next = ST_IDLE;
    endcase
    run = (state_next == ST_RUN);
  end

  always_comb begin
    h_next = '0;
    v_next = '0;
    if (run) begin
      if (h_cnt == H_LAST) begin
        h_next = '0;
        v_next = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
      end else begin
        h_next = h_cnt + CNT_W'(1);
        v_next = v_cnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  always_comb begin
    de  = run && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs  = run && (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs  = run && (v_cnt >= VS_START) && (v_cnt < VS_END);
    sof = run && (h_cnt == '0) && (v_cnt == '0);
    x   = h_cnt;
    y   = v_cnt;
  end

endmodule

// File: rtl/vid_pattern_gen.sv
// Test-pattern video source standing in for the DVI receiver ahead of img_proc.
// Patterns are latched once per frame and every output is registered once.
module vid_pattern_gen
  import vid_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CHK_LOG2 = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          pat_sel,
  input  logic [23:0]         solid_rgb,
  vid_pattern_gen_if.master   vid
);

  localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);
  localparam logic [23:0]      WHITE = pack_rbg(8'hFF, 8'hFF, 8'hFF);

  logic             run;
  logic             de;
  logic             hs;
  logic             vs;
  logic             sof;
  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;

  vid_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .run   (run),
    .de    (de),
    .hs    (hs),
    .vs    (vs),
    .sof   (sof),
    .x     (x),
    .y     (y)
  );

  pat_e             pat_q;
  logic [23:0]      solid_q;
  pat_e             pat_cur;
  logic [23:0]      solid_cur;
  logic [CNT_W-1:0] bar_left_q;
  logic [2:0]       bar_idx_q;
  logic [CNT_W-1:0] bar_left;
  logic [2:0]       bar_idx;
  logic [CNT_W-1:0] bar_left_next;
  logic [2:0]       bar_idx_next;
  logic [23:0]      pixel;

  // Selection is sampled at the frame origin; that pixel itself already uses the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q   <= PAT_BARS;
      solid_q <= '0;
    end else if (sof) begin
      pat_q   <= pat_e'(pat_sel);
      solid_q <= solid_rgb;
    end
  end

  always_comb begin
    pat_cur   = sof ? pat_e'(pat_sel) : pat_q;
    solid_cur = sof ? solid_rgb : solid_q;
  end

  always_comb begin
    bar_idx  = bar_idx_q;
    bar_left = bar_left_q;
    if (de && (x == '0)) begin
      bar_idx  = 3'd0;
      bar_left = BAR_W;
    end
    if (bar_left == CNT_W'(1)) begin
      bar_idx_next  = bar_idx + 3'd1;
      bar_left_next = BAR_W;
    end else begin
      bar_idx_next  = bar_idx;
      bar_left_next = bar_left - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_idx_q  <= 3'd0;
      bar_left_q <= BAR_W;
    end else if (de) begin
      bar_idx_q  <= bar_idx_next;
      bar_left_q <= bar_left_next;
    end
  end

  always_comb begin
    pixel = '0;
    if (de) begin
      case (pat_cur)
        PAT_BARS:  pixel = BAR_TABLE[bar_idx];
        PAT_CHECK: pixel = (x[CHK_LOG2] ^ y[CHK_LOG2]) ? WHITE : 24'h000000;
        PAT_GRAD:  pixel = pack_rbg(x[7:0], x[7:0], x[7:0]);
        PAT_SOLID: pixel = solid_cur;
        default:   pixel = '0;
      endcase
    end
  end

  // Leaving RUN drops everything back to reset values on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid.data_o  <= '0;
      vid.vde_o   <= 1'b0;
      vid.hsync_o <= ~SYNC_POL;
      vid.vsync_o <= ~SYNC_POL;
      vid.x_o     <= '0;
      vid.y_o     <= '0;
      vid.sof_o   <= 1'b0;
    end else if (!run) begin
      vid.data_o  <= '0;
      vid.vde_o   <= 1'b0;
      vid.hsync_o <= ~SYNC_POL;
      vid.vsync_o <= ~SYNC_POL;
      vid.x_o     <= '0;
      vid.y_o     <= '0;
      vid.sof_o   <= 1'b0;
    end else begin
      vid.data_o  <= pixel;
      vid.vde_o   <= de;
      vid.hsync_o <= hs ? SYNC_POL : ~SYNC_POL;
      vid.vsync_o <= vs ? SYNC_POL : ~SYNC_POL;
      vid.sof_o   <= sof;
      if (de) begin
        vid.x_o <= x;
        vid.y_o <= y;
      end
    end
  end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen on a 24x7 raster; an independent raster model
// queues the expected output for each edge and the observed outputs are popped against it.
module tb_vid_pattern_gen;
  import vid_pkg::*;

  typedef struct packed {
    logic [23:0] data;
    logic        vde;
    logic        hsync;
    logic        vsync;
    logic [11:0] x;
    logic [11:0] y;
    logic        sof;
  } obs_t;

  localparam obs_t RESET_OBS = '{data: 24'h0, vde: 1'b0, hsync: 1'b1, vsync: 1'b1,
                                 x: 12'd0, y: 12'd0, sof: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pat_sel = 2'd0;
  logic [23:0] solid_rgb = 24'h0;

  vid_pattern_gen_if vif ();

  vid_pattern_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (4),  .V_FP (1), .V_SYNC (1), .V_BP (1),
    .SYNC_POL (1'b0), .CHK_LOG2 (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pat_sel   (pat_sel),
    .solid_rgb (solid_rgb),
    .vid       (vif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  obs_t sb[$];

  int          m_h = 0;
  int          m_v = 0;
  logic [1:0]  m_pat = 2'd0;
  logic [23:0] m_solid = 24'h0;
  logic [11:0] m_x = 12'd0;
  logic [11:0] m_y = 12'd0;

  int   since_sof = 0;
  int   sof_gap = 0;
  int   sof_cnt = 0;
  int   vde_cnt = 0;
  int   vs_low = 0;
  int   vs_first = -1;
  int   hs_low = 0;
  int   hs_pulses = 0;
  logic prev_hs = 1'b1;
  obs_t last_obs;

  function automatic logic [23:0] exp_pixel(int px, int py, logic [1:0] pat, logic [23:0] solid);
    logic [7:0] g;
    g = 8'(px);
    case (pat)
      2'd0: case (px / 2)
              0: return 24'hFFFFFF;
              1: return 24'hFF00FF;
              2: return 24'h00FFFF;
              3: return 24'h0000FF;
              4: return 24'hFFFF00;
              5: return 24'hFF0000;
              6: return 24'h00FF00;
              default: return 24'h000000;
            endcase
      2'd1: return ((((px / 4) + (py / 4)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
      2'd2: return {g, g, g};
      default: return solid;
    endcase
  endfunction

  task automatic model_push();
    obs_t e;
    bit   active;
    if (!(en && rst_n)) begin
      e = RESET_OBS;
      m_h = 0; m_v = 0; m_x = 12'd0; m_y = 12'd0;
    end else begin
      if (m_h == 0 && m_v == 0) begin
        m_pat = pat_sel;
        m_solid = solid_rgb;
      end
      active = (m_h < 16) && (m_v < 4);
      if (active) begin
        m_x = 12'(m_h);
        m_y = 12'(m_v);
      end
      e.data  = active ? exp_pixel(m_h, m_v, m_pat, m_solid) : 24'h0;
      e.vde   = active;
      e.hsync = (m_h >= 18 && m_h < 21) ? 1'b0 : 1'b1;
      e.vsync = (m_v == 5) ? 1'b0 : 1'b1;
      e.x     = m_x;
      e.y     = m_y;
      e.sof   = (m_h == 0 && m_v == 0);
      m_h++;
      if (m_h == 24) begin
        m_h = 0;
        m_v++;
        if (m_v == 7) m_v = 0;
      end
    end
    sb.push_back(e);
  endtask

  function automatic obs_t sample();
    return {vif.data_o, vif.vde_o, vif.hsync_o, vif.vsync_o, vif.x_o, vif.y_o, vif.sof_o};
  endfunction

  task automatic clear_stats();
    sof_cnt = 0; vde_cnt = 0; vs_low = 0; vs_first = -1;
    hs_low = 0; hs_pulses = 0; prev_hs = 1'b1;
  endtask

  task automatic check_output(input string tag);
    obs_t e;
    obs_t o;
    e = sb.pop_front();
    o = sample();
    last_obs = o;
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (model h=%0d v=%0d)", tag, o, e, m_h, m_v);
    end
    if (o.sof) begin
      sof_gap = since_sof + 1;
      since_sof = 0;
      sof_cnt++;
    end else begin
      since_sof++;
    end
    if (o.vde) vde_cnt++;
    if (!o.vsync) begin
      if (vs_first < 0) vs_first = since_sof;
      vs_low++;
    end
    if (!o.hsync) hs_low++;
    if (prev_hs && !o.hsync) hs_pulses++;
    prev_hs = o.hsync;
  endtask

  task automatic apply_stimulus(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      model_push();
      @(posedge clk);
      #1;
      check_output(tag);
    end
  endtask

  task automatic run_to(input int h, input int v, input string tag);
    int guard;
    guard = 0;
    while (!(m_h == h && m_v == v) && guard < 400) begin
      apply_stimulus(1, tag);
      guard++;
    end
    if (!(m_h == h && m_v == v)) begin
      checks++;
      errors++;
      $display("FAIL %s position not reached: h=%0d v=%0d required h=%0d v=%0d", tag, m_h, m_v, h, v);
    end
  endtask

  task automatic check_int(input string tag, input int observed, input int expected);
    checks++;
    assert (observed == expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert (sample() === RESET_OBS) else begin
      errors++;
      $error("FAIL reset observed=%h expected=%h", sample(), RESET_OBS);
    end

    rst_n = 1'b1;
    apply_stimulus(2, "idle");

    $display("[TB] colour bars frame, raster statistics");
    en = 1'b1;
    pat_sel = 2'd0;
    clear_stats();
    apply_stimulus(168, "bars");
    check_int("sof_count", sof_cnt, 1);
    check_int("vde_per_frame", vde_cnt, 64);
    check_int("vsync_low", vs_low, 24);
    check_int("vsync_start", vs_first, 120);
    check_int("hsync_low", hs_low, 21);
    check_int("hsync_pulses", hs_pulses, 7);
    apply_stimulus(1, "bars_wrap");
    check_int("sof_period", sof_gap, 168);

    $display("[TB] checkerboard");
    pat_sel = 2'd1;
    apply_stimulus(167 + 168, "check");

    $display("[TB] gradient switched to solid mid-frame");
    pat_sel = 2'd2;
    run_to(5, 1, "grad");
    pat_sel = 2'd3;
    solid_rgb = 24'h12A5C3;
    apply_stimulus(168 - 29 + 168, "grad_solid");

    $display("[TB] enable dropped mid-line");
    pat_sel = 2'd0;
    run_to(7, 2, "pre_dis");
    en = 1'b0;
    apply_stimulus(3, "disabled");
    en = 1'b1;
    apply_stimulus(1, "reenable");
    check_int("reenable_sof", int'(last_obs.sof), 1);
    apply_stimulus(40, "after_en");

    $display("[TB] reset pulsed mid-line");
    run_to(9, 1, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    assert (sample() === RESET_OBS) else begin
      errors++;
      $error("FAIL async_reset observed=%h expected=%h", sample(), RESET_OBS);
    end
    apply_stimulus(2, "in_reset");
    rst_n = 1'b1;
    apply_stimulus(1, "post_rst");
    check_int("post_rst_sof", int'(last_obs.sof), 1);
    apply_stimulus(60, "post_rst_run");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
